// File: rtl/fra_pkg.sv
// Shared definitions for the frequency-response sweep path: sequencer
// state encoding, default capture length and sample-RAM word layout.
package fra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT
  } state_t;

  // Words captured per sweep point
  localparam int CAP_LEN = 4096;

  // Packed RAM word: sine in the upper field, ADC sample in the lower one
  localparam int PACK_SIN_MSB = 31;
  localparam int PACK_SIN_LSB = 20;
  localparam int PACK_ADC_MSB = 15;
  localparam int PACK_ADC_LSB = 4;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter used for the per-point settle interval.
// Saturates at zero; o_zero flags the final settle cycle.
module settle_timer #(
  parameter int SETTLE_W = 20
) (
  input  logic                clk_50M,
  input  logic                reset_n,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_load_val,
  input  logic                i_dec,
  output logic                o_zero
);

  logic [SETTLE_W-1:0] r_cnt;

  // Load has priority; otherwise count down while enabled, stopping at zero
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency-response sweep sequencer (clk_50M domain).
// Per point: program phi_inc, settle, capture CAP_LEN packed words into
// the sample RAM, request a UDP transmit and wait for its completion.
// Optional build macro SWEEP_AUTO_RESTART_EN: a finished sweep pulses
// sweep_done and restarts from the latched start increment until abort.
module sweep_sequencer #(
  parameter int PHI_W    = 11,
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 12,
  parameter int CAP_LEN  = fra_pkg::CAP_LEN,
  parameter int SETTLE_W = 20
) (
  input  logic                     clk_50M,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [PHI_W-1:0]         cfg_phi_start,
  input  logic [PHI_W-1:0]         cfg_phi_stop,
  input  logic [PHI_W-1:0]         cfg_phi_step,
  input  logic [SETTLE_W-1:0]      cfg_settle,
  input  logic signed [DATA_W-1:0] sin_do,
  input  logic signed [DATA_W-1:0] ad_in,
  input  logic                     tx_done,
  output logic [PHI_W-1:0]         phi_inc,
  output logic                     ram_wren,
  output logic [ADDR_W-1:0]        ram_wr_addr,
  output logic [31:0]              ram_wr_data,
  output logic                     send_trigger,
  output logic                     busy,
  output logic                     sweep_done,
  output logic [15:0]              point_idx
);
  import fra_pkg::*;

  state_t              r_state;
  logic [PHI_W-1:0]    r_phi_inc;
  logic                r_ram_wren;
  logic [ADDR_W-1:0]   r_ram_wr_addr;
  logic [31:0]         r_ram_wr_data;
  logic                r_send_trigger;
  logic                r_busy;
  logic                r_sweep_done;
  logic [15:0]         r_point_idx;
  logic [ADDR_W-1:0]   r_cap_cnt;

  // Shadow copies of the configuration, frozen for the whole sweep
  logic [PHI_W-1:0]    r_phi_start;
  logic [PHI_W-1:0]    r_phi_stop;
  logic [PHI_W-1:0]    r_phi_step;
  logic [SETTLE_W-1:0] r_settle;

  logic                w_settle_zero;
  logic                w_settle_load;
  logic [SETTLE_W-1:0] w_settle_val;
  logic [PHI_W:0]      w_phi_sum;
  logic                w_last;

  function automatic logic [31:0] pack_word(input logic signed [DATA_W-1:0] s,
                                            input logic signed [DATA_W-1:0] a);
    logic [31:0] w;
    w = '0;
    w[PACK_SIN_MSB:PACK_SIN_LSB] = s;
    w[PACK_ADC_MSB:PACK_ADC_LSB] = a;
    return w;
  endfunction

  // The timer is reloaded in every state except SETTLE, so it always holds
  // the right interval on entry; in IDLE it tracks the live cfg input so the
  // start cycle itself loads the new value.
  assign w_settle_load = (r_state != ST_SETTLE);
  assign w_settle_val  = (r_state == ST_IDLE) ? cfg_settle : r_settle;

  settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk_50M    (clk_50M),
    .reset_n    (reset_n),
    .i_load     (w_settle_load),
    .i_load_val (w_settle_val),
    .i_dec      (r_state == ST_SETTLE),
    .o_zero     (w_settle_zero)
  );

  // Extra carry bit keeps an increment that passes the top of the range
  // from wrapping into a small, apparently valid value.
  assign w_phi_sum = {1'b0, r_phi_inc} + {1'b0, r_phi_step};
  assign w_last    = (w_phi_sum > {1'b0, r_phi_stop}) || (r_phi_step == '0);

  // Latch the configuration when a sweep is accepted
  always_ff @(posedge clk_50M) begin
    if ((r_state == ST_IDLE) && start && !abort) begin
      r_phi_start <= cfg_phi_start;
      r_phi_stop  <= cfg_phi_stop;
      r_phi_step  <= cfg_phi_step;
      r_settle    <= cfg_settle;
    end
  end

  // Sequencer FSM with registered outputs; abort overrides every state
  always_ff @(posedge clk_50M) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_phi_inc      <= '0;
      r_ram_wren     <= 1'b0;
      r_ram_wr_addr  <= '0;
      r_ram_wr_data  <= '0;
      r_send_trigger <= 1'b0;
      r_busy         <= 1'b0;
      r_sweep_done   <= 1'b0;
      r_point_idx    <= '0;
      r_cap_cnt      <= '0;
    end else begin
      r_ram_wren     <= 1'b0;
      r_send_trigger <= 1'b0;
      r_sweep_done   <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_phi_inc   <= cfg_phi_start;
              r_point_idx <= '0;
              r_busy      <= 1'b1;
              r_state     <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (w_settle_zero) begin
              r_cap_cnt <= '0;
              r_state   <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            r_ram_wren    <= 1'b1;
            r_ram_wr_addr <= r_cap_cnt;
            r_ram_wr_data <= pack_word(sin_do, ad_in);
            if (r_cap_cnt == ADDR_W'(CAP_LEN - 1)) begin
              r_state <= ST_SEND;
            end else begin
              r_cap_cnt <= r_cap_cnt + 1'b1;
            end
          end
          ST_SEND: begin
            r_send_trigger <= 1'b1;
            r_state        <= ST_WAIT_TX;
          end
          ST_WAIT_TX: begin
            if (tx_done) begin
              r_state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (w_last) begin
              r_sweep_done <= 1'b1;
`ifdef SWEEP_AUTO_RESTART_EN
              r_phi_inc   <= r_phi_start;
              r_point_idx <= '0;
              r_state     <= ST_SETTLE;
`else
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
`endif
            end else begin
              r_phi_inc   <= w_phi_sum[PHI_W-1:0];
              r_point_idx <= r_point_idx + 16'd1;
              r_state     <= ST_SETTLE;
            end
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign phi_inc      = r_phi_inc;
  assign ram_wren     = r_ram_wren;
  assign ram_wr_addr  = r_ram_wr_addr;
  assign ram_wr_data  = r_ram_wr_data;
  assign send_trigger = r_send_trigger;
  assign busy         = r_busy;
  assign sweep_done   = r_sweep_done;
  assign point_idx    = r_point_idx;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer. A monitor checks every RAM write
// against the bench's own packing of the driven samples and pops the
// expected phase increment of each point when send_trigger fires.
module tb_sweep_sequencer;

  localparam int PHI_W    = 11;
  localparam int DATA_W   = 12;
  localparam int ADDR_W   = 12;
  localparam int CAP_LEN  = 4096;
  localparam int SETTLE_W = 20;

  logic                     clk_50M = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     start = 1'b0;
  logic                     abort = 1'b0;
  logic [PHI_W-1:0]         cfg_phi_start = '0;
  logic [PHI_W-1:0]         cfg_phi_stop = '0;
  logic [PHI_W-1:0]         cfg_phi_step = '0;
  logic [SETTLE_W-1:0]      cfg_settle = '0;
  logic signed [DATA_W-1:0] sin_do = '0;
  logic signed [DATA_W-1:0] ad_in = '0;
  logic                     tx_done = 1'b0;
  logic [PHI_W-1:0]         phi_inc;
  logic                     ram_wren;
  logic [ADDR_W-1:0]        ram_wr_addr;
  logic [31:0]              ram_wr_data;
  logic                     send_trigger;
  logic                     busy;
  logic                     sweep_done;
  logic [15:0]              point_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int n_trig   = 0;
  int n_done   = 0;
  int wr_cnt   = 0;
  int exp_addr = 0;
  int exp_q[$];

  always #10 clk_50M = ~clk_50M;

  sweep_sequencer #(
    .PHI_W    (PHI_W),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .CAP_LEN  (CAP_LEN),
    .SETTLE_W (SETTLE_W)
  ) dut (
    .clk_50M       (clk_50M),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .cfg_phi_start (cfg_phi_start),
    .cfg_phi_stop  (cfg_phi_stop),
    .cfg_phi_step  (cfg_phi_step),
    .cfg_settle    (cfg_settle),
    .sin_do        (sin_do),
    .ad_in         (ad_in),
    .tx_done       (tx_done),
    .phi_inc       (phi_inc),
    .ram_wren      (ram_wren),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .send_trigger  (send_trigger),
    .busy          (busy),
    .sweep_done    (sweep_done),
    .point_idx     (point_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: writes, per-point scoreboard, then new random samples
  always @(negedge clk_50M) begin
    if (reset_n) begin
      if (ram_wren) begin
        check("wr_addr", 32'(ram_wr_addr), 32'(exp_addr));
        check("wr_data", ram_wr_data, {sin_do, 4'd0, ad_in, 4'd0});
        exp_addr++;
        wr_cnt++;
      end
      if (send_trigger) begin
        n_trig++;
        check("pt_writes", 32'(wr_cnt), 32'(CAP_LEN));
        check("pt_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("pt_phi", 32'(phi_inc), 32'(exp_q.pop_front()));
        wr_cnt   = 0;
        exp_addr = 0;
      end
      if (sweep_done) n_done++;
    end
    sin_do = DATA_W'($urandom);
    ad_in  = DATA_W'($urandom);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int se);
    cfg_phi_start = PHI_W'(s);
    cfg_phi_stop  = PHI_W'(e);
    cfg_phi_step  = PHI_W'(st);
    cfg_settle    = SETTLE_W'(se);
  endtask

  // Pulse start and measure cycles until the first write appears
  task automatic do_start(input int settle);
    int k;
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    k = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!ram_wren && k < settle + 50) begin
      @(negedge clk_50M);
      k++;
    end
    check("start_to_wren", 32'(k - 1), 32'(settle + 2));
  endtask

  task automatic wait_trig(input int idx);
    int k;
    k = 0;
    while (!send_trigger && k < 20000) begin
      @(negedge clk_50M);
      k++;
    end
    check("trig_seen", 32'(send_trigger), 32'd1);
    check("point_idx", 32'(point_idx), 32'(idx));
  endtask

  task automatic finish_point(input int phi_cur, input bit last, input int phi_next);
    tick(3);
    check("wait_phi", 32'(phi_inc), 32'(phi_cur));
    tx_done = 1'b1;
    @(negedge clk_50M);
    tx_done = 1'b0;
    check("next_phi_hold", 32'(phi_inc), 32'(phi_cur));
    @(negedge clk_50M);
    if (last) begin
      check("sweep_done_pulse", 32'(sweep_done), 32'd1);
      @(negedge clk_50M);
      check("sweep_done_low", 32'(sweep_done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
    end else begin
      check("next_phi", 32'(phi_inc), 32'(phi_next));
      check("no_done_mid", 32'(sweep_done), 32'd0);
    end
  endtask

  // Absolute bound on run time
  initial begin
    #1800000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    int trig0;
    int done0;

    tick(3);
    check("rst_phi", 32'(phi_inc), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_addr", 32'(ram_wr_addr), 32'd0);
    check("rst_data", ram_wr_data, 32'd0);
    check("rst_trig", 32'(send_trigger), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_idx", 32'(point_idx), 32'd0);
    reset_n = 1'b1;
    tick(2);

`ifdef SWEEP_AUTO_RESTART_EN
    // Auto restart: two points, then the sweep repeats from start
    set_cfg(19, 20, 1, 4);
    exp_q.push_back(19); exp_q.push_back(20); exp_q.push_back(19);
    do_start(4);
    wait_trig(0);
    finish_point(19, 1'b0, 20);
    wait_trig(1);
    tick(3);
    tx_done = 1'b1;
    @(negedge clk_50M);
    tx_done = 1'b0;
    @(negedge clk_50M);
    check("ar_done_pulse", 32'(sweep_done), 32'd1);
    check("ar_phi_reload", 32'(phi_inc), 32'd19);
    check("ar_busy_held", 32'(busy), 32'd1);
    check("ar_idx_clear", 32'(point_idx), 32'd0);
    wait_trig(0);
    abort = 1'b1;
    @(negedge clk_50M);
    abort = 1'b0;
    check("ar_abort_idle", 32'(busy), 32'd0);
    tick(5);
    check("ar_done_count", 32'(n_done), 32'd1);
    check("ar_queue_empty", 32'(exp_q.size()), 32'd0);
`else
    // Basic three-point sweep
    set_cfg(19, 21, 1, 10);
    exp_q.push_back(19); exp_q.push_back(20); exp_q.push_back(21);
    do_start(10);
    wait_trig(0);
    finish_point(19, 1'b0, 20);
    wait_trig(1);
    finish_point(20, 1'b0, 21);
    wait_trig(2);
    finish_point(21, 1'b1, 0);

    // Top of range: 2050 must not wrap into a third point
    set_cfg(2040, 2047, 5, 3);
    exp_q.push_back(2040); exp_q.push_back(2045);
    do_start(3);
    wait_trig(0);
    finish_point(2040, 1'b0, 2045);
    wait_trig(1);
    finish_point(2045, 1'b1, 0);

    // Abort mid-capture at address 100
    trig0 = n_trig;
    done0 = n_done;
    set_cfg(19, 21, 1, 5);
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    k = 0;
    while (!(ram_wren && ram_wr_addr == ADDR_W'(100)) && k < 300) begin
      @(negedge clk_50M);
      k++;
    end
    check("abort_addr_reached", 32'(ram_wr_addr), 32'd100);
    abort = 1'b1;
    @(negedge clk_50M);
    abort = 1'b0;
    check("abort_wren", 32'(ram_wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    tick(20);
    check("abort_no_trig", 32'(n_trig), 32'(trig0));
    check("abort_no_done", 32'(n_done), 32'(done0));
    check("abort_phi_hold", 32'(phi_inc), 32'd19);
    wr_cnt = 0;
    exp_addr = 0;

    // Long tx stall with a stray tx_done during SETTLE
    set_cfg(100, 100, 1, 50);
    exp_q.push_back(100);
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    tick(5);
    tx_done = 1'b1;
    @(negedge clk_50M);
    tx_done = 1'b0;
    wait_trig(0);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_50M);
      if (phi_inc != PHI_W'(100) || ram_wren || send_trigger || !busy) bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);
    finish_point(100, 1'b1, 0);

    // step = 0 gives one point; a start while busy is ignored
    set_cfg(7, 100, 0, 2);
    exp_q.push_back(7);
    do_start(2);
    set_cfg(300, 400, 1, 0);
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    wait_trig(0);
    finish_point(7, 1'b1, 0);

    // start > stop gives one point at start
    set_cfg(50, 10, 3, 1);
    exp_q.push_back(50);
    do_start(1);
    wait_trig(0);
    finish_point(50, 1'b1, 0);

    // settle = 0: first write two cycles after start
    set_cfg(1, 1, 1, 0);
    exp_q.push_back(1);
    do_start(0);
    wait_trig(0);
    finish_point(1, 1'b1, 0);

    // start and abort together from IDLE: abort wins
    set_cfg(9, 9, 1, 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    abort = 1'b0;
    tick(3);
    check("start_abort_idle", 32'(busy), 32'd0);
    check("start_abort_nowr", 32'(ram_wren), 32'd0);

    check("done_count", 32'(n_done), 32'd6);
    check("trig_count", 32'(n_trig), 32'd9);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-sweep clears everything
    set_cfg(19, 21, 1, 2);
    do_start(2);
    tick(10);
    reset_n = 1'b0;
    @(negedge clk_50M);
    check("mrst_wren", 32'(ram_wren), 32'd0);
    check("mrst_phi", 32'(phi_inc), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(ram_wr_addr), 32'd0);
    check("mrst_data", ram_wr_data, 32'd0);
    reset_n = 1'b1;
    wr_cnt = 0;
    exp_addr = 0;
    tick(10);
    check("mrst_stays_idle", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
